// File: rtl/dac_spi_8bit_pkg.sv
// Shared synth package: FSM state type, MCP4921 command-nibble fields and
// 12 MHz clock defaults used by the DAC output stage and the oscillators.
package dac_spi_8bit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LATCH = 3'd4
    } dac_state_t;

    // MCP4921 command nibble, MSB first: A/B select, BUF, GA_n, SHDN_n
    localparam logic MCP_SEL_CH_A   = 1'b0;
    localparam logic MCP_SEL_CH_B   = 1'b1;
    localparam logic MCP_VREF_UNBUF = 1'b0;
    localparam logic MCP_VREF_BUF   = 1'b1;
    localparam logic MCP_GAIN_2X    = 1'b0;
    localparam logic MCP_GAIN_1X    = 1'b1;
    localparam logic MCP_SHUTDOWN   = 1'b0;
    localparam logic MCP_ACTIVE     = 1'b1;

    localparam logic [3:0] MCP_CFG_DEFAULT =
        {MCP_SEL_CH_A, MCP_VREF_UNBUF, MCP_GAIN_1X, MCP_ACTIVE};

    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_SAMPLE_DIV = 272;

    localparam int unsigned FRAME_BITS = 16;

    // The 8-bit sample is left-justified into the DAC's 12-bit code
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [3:0] cfg,
        input logic [7:0] smp
    );
        return {cfg, smp, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_spi_8bit_sample_rate_div.sv
// Parameterised wrap counter producing a one-cycle tick every DIV clocks;
// shared between the DAC output stage and the oscillator stages.
module sample_rate_div #(
    parameter int unsigned DIV = 272
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == CW'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/dac_spi_8bit.sv
// Audio output stage: samples the oscillator word at a fixed rate and writes
// it to an MCP4921-class DAC over SPI mode 0, then strobes LDAC.
module dac_spi_8bit
    import dac_spi_8bit_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter logic [3:0]  CFG_BITS   = MCP_CFG_DEFAULT
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic [7:0] sample,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       dac_ldac_n,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    dac_state_t            r_state;
    dac_state_t            w_state_next;
    logic [HCW-1:0]        r_hc;
    logic [HCW-1:0]        w_hc_next;
    logic                  r_phase;
    logic                  w_phase_next;
    logic [3:0]            r_bit;
    logic [3:0]            w_bit_next;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_frame;

    logic w_tick;
    logic w_hc_last;
    logic w_accept;
    logic w_fall;

    logic r_cs_n;
    logic r_sclk;
    logic r_ldac_n;
    logic r_busy;
    logic r_frame_done;
    logic r_overrun;
    logic w_cs_n_next;
    logic w_sclk_next;
    logic w_ldac_n_next;
    logic w_done_next;

    sample_rate_div #(
        .DIV (SAMPLE_DIV)
    ) u_rate_div (
        .i_clk  (clk12MHz),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign w_hc_last = (r_hc == HCW'(CLK_DIV - 1));
    assign w_accept  = (r_state == ST_IDLE) && w_tick;
    assign w_fall    = (r_state == ST_SHIFT) && r_phase && w_hc_last;
    assign w_frame   = build_frame(CFG_BITS, sample);

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hc    <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_next;
            r_hc    <= w_hc_next;
            r_phase <= w_phase_next;
            r_bit   <= w_bit_next;
        end
    end

    // Every timed state lasts CLK_DIV cycles; SHIFT alternates low/high phases
    always_comb begin
        w_state_next = r_state;
        w_hc_next    = '0;
        w_phase_next = r_phase;
        w_bit_next   = r_bit;
        if (r_state != ST_IDLE && !w_hc_last) begin
            w_hc_next = r_hc + 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_hc_last) begin
                    w_state_next = ST_SHIFT;
                    w_phase_next = 1'b0;
                    w_bit_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (w_hc_last) begin
                    if (!r_phase) begin
                        w_phase_next = 1'b1;
                    end else begin
                        w_phase_next = 1'b0;
                        if (r_bit == 4'd15) begin
                            w_state_next = ST_HOLD;
                        end else begin
                            w_bit_next = r_bit + 4'd1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_hc_last) begin
                    w_state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (w_hc_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the pins switch with it
    always_comb begin
        w_cs_n_next   = 1'b1;
        w_sclk_next   = 1'b0;
        w_ldac_n_next = 1'b1;
        w_done_next   = (r_state == ST_LATCH) && w_hc_last;
        case (w_state_next)
            ST_SETUP, ST_HOLD: begin
                w_cs_n_next = 1'b0;
            end
            ST_SHIFT: begin
                w_cs_n_next = 1'b0;
                w_sclk_next = w_phase_next;
            end
            ST_LATCH: begin
                w_ldac_n_next = 1'b0;
            end
            default: begin
                w_cs_n_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_ldac_n     <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cs_n       <= w_cs_n_next;
            r_sclk       <= w_sclk_next;
            r_ldac_n     <= w_ldac_n_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_frame_done <= w_done_next;
            r_overrun    <= r_overrun | (w_tick && (r_state != ST_IDLE));
        end
    end

    // MOSI is the shifter MSB; zeros shift in so the line idles low afterwards
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= w_frame;
        end else if (w_fall) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign dac_cs_n   = r_cs_n;
    assign dac_sclk   = r_sclk;
    assign dac_mosi   = r_shift[FRAME_BITS-1];
    assign dac_ldac_n = r_ldac_n;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_dac_spi_8bit.sv
// Self-checking bench for dac_spi_8bit: three parameterisations driven with
// random samples and compared against a frame-timing and SPI capture model.
`timescale 1ns/1ps
module tb_dac_spi_8bit;

    logic       clk12MHz = 1'b0;
    logic       rstReq   = 1'b1;
    int         sel      = 0;
    int         cdiv     = 2;
    int         sdiv     = 272;
    logic [7:0] sample   = 8'hA5;

    int checks   = 0;
    int failures = 0;

    always #5 clk12MHz = ~clk12MHz;

    logic rst0, rst1, rst2;
    assign rst0 = rstReq || (sel != 0);
    assign rst1 = rstReq || (sel != 1);
    assign rst2 = rstReq || (sel != 2);

    logic cs0, sclk0, mosi0, ldac0, busy0, done0, ovr0;
    logic cs1, sclk1, mosi1, ldac1, busy1, done1, ovr1;
    logic cs2, sclk2, mosi2, ldac2, busy2, done2, ovr2;

    dac_spi_8bit dut0 (
        .clk12MHz (clk12MHz), .rst (rst0), .sample (sample),
        .dac_cs_n (cs0), .dac_sclk (sclk0), .dac_mosi (mosi0),
        .dac_ldac_n (ldac0), .busy (busy0), .frame_done (done0), .overrun (ovr0)
    );

    dac_spi_8bit #(.CLK_DIV(2), .SAMPLE_DIV(40)) dut1 (
        .clk12MHz (clk12MHz), .rst (rst1), .sample (sample),
        .dac_cs_n (cs1), .dac_sclk (sclk1), .dac_mosi (mosi1),
        .dac_ldac_n (ldac1), .busy (busy1), .frame_done (done1), .overrun (ovr1)
    );

    dac_spi_8bit #(.CLK_DIV(1), .SAMPLE_DIV(50)) dut2 (
        .clk12MHz (clk12MHz), .rst (rst2), .sample (sample),
        .dac_cs_n (cs2), .dac_sclk (sclk2), .dac_mosi (mosi2),
        .dac_ldac_n (ldac2), .busy (busy2), .frame_done (done2), .overrun (ovr2)
    );

    logic mCs, mSclk, mMosi, mLdac, mBusy, mDone, mOvr;

    always_comb begin
        mCs = cs0; mSclk = sclk0; mMosi = mosi0; mLdac = ldac0;
        mBusy = busy0; mDone = done0; mOvr = ovr0;
        if (sel == 1) begin
            mCs = cs1; mSclk = sclk1; mMosi = mosi1; mLdac = ldac1;
            mBusy = busy1; mDone = done1; mOvr = ovr1;
        end else if (sel == 2) begin
            mCs = cs2; mSclk = sclk2; mMosi = mosi2; mLdac = ldac2;
            mBusy = busy2; mDone = done2; mOvr = ovr2;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    // Reference model: frame of 35*cdiv cycles starts the cycle after each
    // accepted tick; ticks land every sdiv cycles counted from reset release
    logic       lastRst = 1'b1;
    int         age     = 0;
    int         fStart  = -100000;
    logic       expOvr  = 1'b0;
    logic [15:0] expQ[$];
    logic       prevCs   = 1'b1;
    logic       prevSclk = 1'b0;
    logic [15:0] capWord = '0;
    int         rises    = 0;

    always @(posedge clk12MHz) lastRst = rstReq;

    always @(negedge clk12MHz) begin
        int off;
        bit inFrame;
        if (lastRst) begin
            age      = 0;
            fStart   = -100000;
            expOvr   = 1'b0;
            expQ.delete();
            prevCs   = 1'b1;
            prevSclk = 1'b0;
            capWord  = '0;
            rises    = 0;
        end else begin
            age++;
        end
        off     = age - fStart;
        inFrame = (off >= 0) && (off < 35 * cdiv);

        checkOutput("busy", mBusy, inFrame);
        checkOutput("cs_n", mCs, !(inFrame && off < 34 * cdiv));
        checkOutput("ldac_n", mLdac, !(off >= 34 * cdiv && off < 35 * cdiv));
        checkOutput("frame_done", mDone, (off == 35 * cdiv));
        checkOutput("overrun", mOvr, expOvr);
        if (age == 0) begin
            checkOutput("rstSclk", mSclk, 0);
            checkOutput("rstMosi", mMosi, 0);
        end

        if (!lastRst) begin
            if (!prevSclk && mSclk) begin
                capWord = {capWord[14:0], mMosi};
                rises++;
            end
            if (!prevCs && mCs) begin
                checkOutput("sclkRises", rises, 16);
                checkOutput("pendingFrames", expQ.size(), 1);
                if (expQ.size() > 0) checkOutput("spiWord", capWord, expQ.pop_front());
                rises = 0;
            end
            prevSclk = mSclk;
            prevCs   = mCs;
        end

        if (age % sdiv == sdiv - 1) begin
            if (inFrame) begin
                expOvr = 1'b1;
            end else begin
                fStart = age + 1;
                expQ.push_back({4'h3, sample, 4'h0});
            end
        end
    end

    // mode 0 holds the sample, mode 1 draws a new random sample every cycle
    task automatic applyStimulus(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk12MHz);
            #2;
            if (mode != 0) sample = 8'($urandom);
        end
    endtask

    task automatic applyReset(input int newSel, input int newCdiv, input int newSdiv);
        @(posedge clk12MHz);
        #2 rstReq = 1'b1;
        @(posedge clk12MHz);
        #2;
        sel  = newSel;
        cdiv = newCdiv;
        sdiv = newSdiv;
        repeat (2) @(posedge clk12MHz);
        #2 rstReq = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk12MHz);
        #2 rstReq = 1'b0;

        sample = 8'hA5;
        applyStimulus(272 * 3 + 20, 0);
        sample = 8'hFF;
        applyStimulus(272, 0);
        sample = 8'h00;
        applyStimulus(272, 0);
        applyStimulus(272 * 3, 1);

        // Abort a frame part-way through the shift
        for (int i = 0; i < 2000 && rises != 8; i++) @(posedge clk12MHz);
        checkOutput("waitRise8", rises, 8);
        #2 rstReq = 1'b1;
        @(posedge clk12MHz);
        #2 rstReq = 1'b0;
        applyStimulus(700, 1);

        applyReset(1, 2, 40);
        applyStimulus(400, 1);
        checkOutput("overrunSticky", mOvr, 1);

        applyReset(2, 1, 50);
        applyStimulus(300, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
